// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: one byte per transfer, MSB first.
// Drives per-cycle half-period SCK levels, MOSI and an active-low channel
// select toward the output multiplexer. MISO is sampled through a
// programmable delay line that compensates for the pin registers.
module spi_master_engine #(
  parameter int DIV      = 4,
  parameter int RX_DELAY = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Start,
  input  logic       FastMode,
  input  logic       CsAssert,
  input  logic [7:0] TxData,
  input  logic       InSPIDi,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] RxData,
  output logic       ClockRunning,
  output logic       ClockStretch,
  output logic       SPIDo,
  output logic       SPISel
);

  localparam logic [7:0] DIV_M1 = 8'(DIV - 1);
  localparam logic [7:0] TAP_MASK = 8'(1) << RX_DELAY;

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t      state;
  logic        fastLatched;
  logic [7:0]  txShift;     // bits still to send, next one in [7]
  logic [2:0]  bitCnt;
  logic [7:0]  divCnt;      // cycles left in the current half-period minus one
  logic        sckHigh;     // slow mode: currently in the SCK-high half
  logic        hiStart;     // this cycle is a bit's first SCK-high cycle
  logic [6:0]  hiDly;
  logic [7:0]  hiTap;
  logic        samplePulse;
  logic [7:0]  rxShift;
  logic [2:0]  rxCnt;
  logic        finish;
  logic [7:0]  rxNext;

  // Delay-line taps: tap 0 is the SCK-high marker itself, tap N is N cycles later
  always_comb begin
    hiTap       = {hiDly, hiStart};
    samplePulse = |(hiTap & TAP_MASK);
    rxNext      = {rxShift[6:0], InSPIDi};
    finish      = samplePulse && (rxCnt == 3'd7);
  end

  // Sample scheduling runs independently of the shift FSM
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      hiDly   <= '0;
      rxShift <= '0;
      rxCnt   <= '0;
    end else begin
      hiDly <= hiTap[6:0];
      if (samplePulse) begin
        rxShift <= rxNext;
        rxCnt   <= rxCnt + 3'd1;
      end
    end
  end

  // Channel select follows CsAssert every cycle, independent of transfers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) SPISel <= 1'b1;
    else         SPISel <= ~CsAssert;
  end

  // Transfer FSM with registered clock-level, MOSI and handshake outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      fastLatched  <= 1'b0;
      txShift      <= '0;
      bitCnt       <= '0;
      divCnt       <= '0;
      sckHigh      <= 1'b0;
      hiStart      <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      RxData       <= '0;
      ClockRunning <= 1'b0;
      ClockStretch <= 1'b0;
      SPIDo        <= 1'b0;
    end else begin
      Done    <= 1'b0;
      hiStart <= 1'b0;
      case (state)
        IDLE: begin
          ClockRunning <= 1'b0;
          ClockStretch <= 1'b0;
          if (Start) begin
            txShift     <= {TxData[6:0], 1'b0};
            SPIDo       <= TxData[7];
            fastLatched <= FastMode;
            bitCnt      <= '0;
            divCnt      <= DIV_M1;
            sckHigh     <= 1'b0;
            Busy        <= 1'b1;
            state       <= SHIFT;
            if (FastMode) begin
              ClockStretch <= 1'b1;
              hiStart      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (fastLatched) begin
            if (bitCnt == 3'd7) begin
              bitCnt       <= '0;
              ClockStretch <= 1'b0;
              state        <= DRAIN;
            end else begin
              bitCnt       <= bitCnt + 3'd1;
              SPIDo        <= txShift[7];
              txShift      <= {txShift[6:0], 1'b0};
              ClockStretch <= 1'b1;
              hiStart      <= 1'b1;
            end
          end else if (divCnt != 8'd0) begin
            divCnt <= divCnt - 8'd1;
          end else if (!sckHigh) begin
            sckHigh      <= 1'b1;
            ClockRunning <= 1'b1;
            ClockStretch <= 1'b1;
            hiStart      <= 1'b1;
            divCnt       <= DIV_M1;
          end else begin
            sckHigh      <= 1'b0;
            ClockRunning <= 1'b0;
            ClockStretch <= 1'b0;
            divCnt       <= DIV_M1;
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
              state  <= DRAIN;
            end else begin
              bitCnt  <= bitCnt + 3'd1;
              SPIDo   <= txShift[7];
              txShift <= {txShift[6:0], 1'b0};
            end
          end
        end
        DRAIN: begin
          ClockRunning <= 1'b0;
          ClockStretch <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      // The 8th sample ends the transfer wherever the FSM happens to be
      if (finish) begin
        state        <= IDLE;
        Busy         <= 1'b0;
        Done         <= 1'b1;
        RxData       <= rxNext;
        bitCnt       <= '0;
        ClockRunning <= 1'b0;
        ClockStretch <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: table of directed transfers, randomized
// transfers against a cycle-timeline model, and hand-written corner cases.
module tb_spi_master_engine;

  localparam int DIV = 4;
  localparam int RXD = 2;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       Start = 1'b0;
  logic       FastMode = 1'b0;
  logic       CsAssert = 1'b0;
  logic [7:0] TxData = 8'h00;
  logic       InSPIDi = 1'b0;
  logic       Busy, Done, ClockRunning, ClockStretch, SPIDo, SPISel;
  logic [7:0] RxData;

  int checks = 0;
  int errors = 0;
  logic [7:0] lastRx = 8'h00;

  spi_master_engine #(.DIV(DIV), .RX_DELAY(RXD)) dut (
    .Clk(Clk), .nReset(nReset), .Start(Start), .FastMode(FastMode),
    .CsAssert(CsAssert), .TxData(TxData), .InSPIDi(InSPIDi), .Busy(Busy),
    .Done(Done), .RxData(RxData), .ClockRunning(ClockRunning),
    .ClockStretch(ClockStretch), .SPIDo(SPIDo), .SPISel(SPISel)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // mode 0: loopback of SPIDo delayed 2 cycles, 1: pattern aligned to
  // sample points, 2: random MISO every cycle (expected from the log)
  task automatic runXfer(input bit fast, input logic [7:0] tx, input int mode,
                         input logic [7:0] pat, input bit useExpRx,
                         input logic [7:0] expRxIn, input int expDone, input bit busyStart);
    int P, H, shiftEnd, D, fs, k, o, j;
    logic spidoLog [0:255];
    logic misoLog [0:255];
    logic [7:0] expRx;
    logic hi;
    P = fast ? 1 : 2 * DIV;
    H = fast ? 0 : DIV;
    shiftEnd = 8 * P;
    fs = 1 + H + RXD;
    D = fs + 7 * P + 1;
    chk("done_cycle_formula", 32'(D), 32'(expDone));
    for (int c = 0; c <= D; c++) begin
      @(negedge Clk);
      if (c == 0) begin
        Start = 1'b1; TxData = tx; FastMode = fast;
        chk("idle_busy", 32'(Busy), 32'd0);
      end else begin
        if (busyStart && c == 4) begin
          Start = 1'b1; TxData = 8'hFF; FastMode = ~fast;
        end else begin
          Start = 1'b0; TxData = 8'($urandom); FastMode = 1'($urandom);
        end
        spidoLog[c] = SPIDo;
        chk("spisel", 32'(SPISel), 32'd0);
        if (c < D) begin
          chk("busy", 32'(Busy), 32'd1);
          chk("done_early", 32'(Done), 32'd0);
          chk("rx_held", 32'(RxData), 32'(lastRx));
          if (c <= shiftEnd) begin
            k = (c - 1) / P;
            o = (c - 1) % P;
            hi = (o >= H);
            chk("spido", 32'(SPIDo), 32'(tx[7-k]));
            chk("clk_run", 32'(ClockRunning), fast ? 32'd0 : 32'(hi));
            chk("clk_str", 32'(ClockStretch), fast ? 32'd1 : 32'(hi));
          end else begin
            chk("drain_spido", 32'(SPIDo), 32'(tx[0]));
            chk("drain_clk", 32'({ClockRunning, ClockStretch}), 32'd0);
          end
        end else begin
          expRx = 8'h00;
          for (int b = 0; b < 8; b++) expRx = {expRx[6:0], misoLog[fs + b * P]};
          if (useExpRx) expRx = expRxIn;
          chk("done", 32'(Done), 32'd1);
          chk("done_busy", 32'(Busy), 32'd0);
          chk("rxdata", 32'(RxData), 32'(expRx));
          chk("done_clk", 32'({ClockRunning, ClockStretch}), 32'd0);
          lastRx = expRx;
        end
      end
      case (mode)
        0: InSPIDi = (c >= 3) ? spidoLog[c-2] : 1'b0;
        1: begin
          j = (c < fs) ? 0 : (c - fs) / P;
          if (j > 7) j = 7;
          InSPIDi = pat[7-j];
        end
        default: InSPIDi = 1'($urandom);
      endcase
      misoLog[c] = InSPIDi;
    end
    Start = 1'b0;
    if (busyStart) begin
      for (int c = 0; c < 15; c++) begin
        @(negedge Clk);
        chk("no_second_done", 32'(Done), 32'd0);
        chk("no_second_busy", 32'(Busy), 32'd0);
      end
    end
  endtask

  typedef struct {
    bit         fast;
    logic [7:0] tx;
    int         mode;
    logic [7:0] pat;
    logic [7:0] expRx;
    int         expDone;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{fast: 1'b1, tx: 8'hA5, mode: 0, pat: 8'h00, expRx: 8'hA5, expDone: 11};
    vecs[1] = '{fast: 1'b0, tx: 8'h3C, mode: 1, pat: 8'hC3, expRx: 8'hC3, expDone: 64};
    vecs[2] = '{fast: 1'b1, tx: 8'h81, mode: 1, pat: 8'h6E, expRx: 8'h6E, expDone: 11};
    vecs[3] = '{fast: 1'b0, tx: 8'hF0, mode: 0, pat: 8'h00, expRx: 8'hF0, expDone: 64};

    // Reset held with Start asserted
    Start = 1'b1; TxData = 8'hFF; FastMode = 1'b1; CsAssert = 1'b1;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_rx", 32'(RxData), 32'd0);
    chk("rst_clk", 32'({ClockRunning, ClockStretch}), 32'd0);
    chk("rst_spido", 32'(SPIDo), 32'd0);
    chk("rst_sel", 32'(SPISel), 32'd1);
    Start = 1'b0;
    nReset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("post_rst_busy", 32'(Busy), 32'd0);
      chk("post_rst_sel", 32'(SPISel), 32'd0);
    end

    // Directed table
    for (int i = 0; i < 4; i++)
      runXfer(vecs[i].fast, vecs[i].tx, vecs[i].mode, vecs[i].pat, 1'b1,
              vecs[i].expRx, vecs[i].expDone, 1'b0);

    // Randomized transfers against the timeline model
    for (int i = 0; i < 6; i++) begin
      bit f;
      f = 1'($urandom);
      runXfer(f, 8'($urandom), 2, 8'h00, 1'b0, 8'h00, f ? 11 : 64, 1'b0);
    end

    // Start while busy is ignored
    runXfer(1'b1, 8'h00, 1, 8'h5A, 1'b1, 8'h5A, 11, 1'b1);

    // Mid-transfer asynchronous reset
    @(negedge Clk);
    Start = 1'b1; TxData = 8'hA5; FastMode = 1'b1; CsAssert = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    chk("pre_abort_busy", 32'(Busy), 32'd1);
    nReset = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_rx", 32'(RxData), 32'd0);
    chk("abort_clk", 32'({ClockRunning, ClockStretch}), 32'd0);
    chk("abort_spido", 32'(SPIDo), 32'd0);
    chk("abort_sel", 32'(SPISel), 32'd1);
    repeat (2) @(negedge Clk);
    nReset = 1'b1; CsAssert = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      chk("abort_no_done", 32'(Done), 32'd0);
      chk("abort_rx_zero", 32'(RxData), 32'd0);
      chk("abort_sel_hi", 32'(SPISel), 32'd1);
    end
    lastRx = 8'h00;

    // Back-to-back with Start held high
    CsAssert = 1'b1; InSPIDi = 1'b0;
    @(negedge Clk);
    Start = 1'b1; FastMode = 1'b1; TxData = 8'($urandom);
    for (int c = 1; c <= 44; c++) begin
      @(negedge Clk);
      TxData = 8'($urandom);
      chk("b2b_busy", 32'(Busy), (c % 11 == 0) ? 32'd0 : 32'd1);
      chk("b2b_done", 32'(Done), (c % 11 == 0) ? 32'd1 : 32'd0);
    end
    Start = 1'b0;
    repeat (12) @(negedge Clk);
    chk("b2b_idle", 32'(Busy), 32'd0);
    chk("b2b_rx", 32'(RxData), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
